instr_packer: RTL and testbench

INSTR_PACKER -- requirements
Module: instr_packer

---
 rtl/instr_packer_if.sv | 26 ++
 rtl/instr_packer.sv | 131 +++++++++++++
 tb/tb_instr_packer.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_packer_if.sv
// Request/instruction handshake bundle for instr_packer.
// master drives requests and out_ready; slave is the packer.
interface instr_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_addr;

  modport master (
    output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_packer.sv
// Packs decoded requests into RV32 I/S/B instruction words at consecutive addresses.
// Optional immediate range checking: define INSTR_PACKER_RANGE_CHECK_EN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting requests until prog_len have been consumed
// DRAIN | waiting for the last held instruction to be taken
// DONE  | one-cycle done pulse
module instr_packer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] prog_len,
  instr_packer_if.slave    bus,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] acc_cnt;
  logic [LEN_W-1:0] len_q;
  logic [31:0]      addr_q;
  logic             out_valid_q;
  logic [31:0]      out_instr_q;
  logic [31:0]      out_addr_q;
  logic [31:0]      enc;
  logic             reject;
  logic             in_ready;
  logic             xfer;

  assign in_ready      = (state == S_RUN) && (acc_cnt < len_q) && (!out_valid_q || bus.out_ready);
  assign xfer          = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;

  always_comb begin
    enc = '0;
    case (bus.in_kind)
      2'd0: enc = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0010011};
      2'd1: enc = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0000011};
      2'd2: enc = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                   bus.in_imm[4:0], 7'b0100011};
      default: enc = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1,
                      bus.in_funct3, bus.in_imm[4:1], bus.in_imm[11], 7'b1100011};
    endcase
  end

`ifdef INSTR_PACKER_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s = $signed(bus.in_imm);

  always_comb begin
    reject = 1'b0;
    if (bus.in_kind == 2'd3)
      reject = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || bus.in_imm[0];
    else
      reject = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
  end
`else
  always_comb begin
    reject = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (acc_cnt == len_q) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!out_valid_q) state_nxt = S_DONE;
      end
      default: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt     <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      err_cnt     <= '0;
      out_valid_q <= 1'b0;
      out_instr_q <= '0;
      out_addr_q  <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        addr_q  <= base_addr;
        len_q   <= prog_len;
        acc_cnt <= '0;
        err_cnt <= '0;
      end
      if (xfer) begin
        acc_cnt <= acc_cnt + LEN_W'(1);
        if (reject) begin
          if (err_cnt != '1) err_cnt <= err_cnt + LEN_W'(1);
        end else begin
          out_instr_q <= enc;
          out_addr_q  <= addr_q;
          addr_q      <= addr_q + 32'd4;
        end
      end
      // A rejected transfer still lets the held word retire on out_ready.
      if (xfer && !reject)    out_valid_q <= 1'b1;
      else if (bus.out_ready) out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// Self-checking bench for instr_packer: directed scenarios plus randomized runs
// scored against a queue-based model of the packing rules.
`timescale 1ns/1ps
module tb_instr_packer;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [LEN_W-1:0] prog_len = '0;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] err_cnt;

  instr_packer_if bus();

  instr_packer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .prog_len(prog_len), .bus(bus.slave), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
  } item_t;

  item_t       prog[$];
  logic [31:0] obs_instr[$];
  logic [31:0] obs_addr[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          done_cycle;
  int          model_rejects;

  function automatic item_t mk(int kind, int rd, int rs1, int rs2, int f3, int imm);
    item_t it;
    it.kind = 2'(kind); it.rd = 5'(rd); it.rs1 = 5'(rs1); it.rs2 = 5'(rs2);
    it.f3 = 3'(f3); it.imm = 32'(imm);
    return it;
  endfunction

  // Field placement computed with shifts and masks from the format tables.
  function automatic logic [31:0] model_enc(item_t it);
    logic [31:0] op, imm, rd, f3, rs1, rs2;
    op  = (it.kind == 0) ? 32'h13 : (it.kind == 1) ? 32'h03 : (it.kind == 2) ? 32'h23 : 32'h63;
    imm = it.imm; rd = 32'(it.rd); f3 = 32'(it.f3); rs1 = 32'(it.rs1); rs2 = 32'(it.rs2);
    if (it.kind < 2)
      return op + (rd << 7) + (f3 << 12) + (rs1 << 15) + ((imm & 32'hfff) << 20);
    if (it.kind == 2)
      return op + ((imm & 32'h1f) << 7) + (f3 << 12) + (rs1 << 15) + (rs2 << 20)
             + (((imm >> 5) & 32'h7f) << 25);
    return op + (((imm >> 11) & 32'h1) << 7) + (((imm >> 1) & 32'hf) << 8) + (f3 << 12)
           + (rs1 << 15) + (rs2 << 20) + (((imm >> 5) & 32'h3f) << 25)
           + (((imm >> 12) & 32'h1) << 31);
  endfunction

  function automatic logic model_reject(item_t it);
`ifdef INSTR_PACKER_RANGE_CHECK_EN
    int v;
    v = int'($signed(it.imm));
    if (it.kind == 3) return (v < -4096) || (v > 4094) || (v % 2 != 0);
    return (v < -2048) || (v > 2047);
`else
    return (it.kind == 4);
`endif
  endfunction

  function automatic logic [31:0] rand_imm();
    int picks[13] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097, -4098, 1, -1, 0};
    case ($urandom_range(0, 2))
      0: return 32'($urandom_range(0, 400)) - 32'd200;
      1: return 32'(picks[$urandom_range(0, 12)]);
      default: return $urandom;
    endcase
  endfunction

  // mode 0: out_ready high; 1: random ready/valid; 2: ready low 3 cycles after first output
  task automatic run_prog(input logic [31:0] base, input int mode, input int budget);
    logic [31:0] exp_i[$];
    logic [31:0] exp_a[$];
    logic [31:0] addr;
    int          idx, cyc, first_out, rejects, n;
    logic        seen_done, exp_valid_next, prev_stall, ov, rdy, exp_rdy, exp_busy;
    logic [31:0] prev_i, prev_a;
    addr = base; idx = 0; cyc = 0; first_out = -1; rejects = 0; n = prog.size();
    seen_done = 0; exp_valid_next = 0; prev_stall = 0; prev_i = '0; prev_a = '0;
    obs_instr.delete(); obs_addr.delete();
    @(negedge clk);
    start = 1'b1; base_addr = base; prog_len = LEN_W'(n); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!seen_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      ov = bus.out_valid;
      if (ov && first_out < 0) first_out = cyc;
      case (mode)
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        2:       bus.out_ready = !(first_out >= 0 && cyc < first_out + 3);
        default: bus.out_ready = 1'b1;
      endcase
      bus.in_valid = (idx < n) && (mode != 1 || $urandom_range(0, 2) != 0);
      if (idx < n) begin
        bus.in_kind = prog[idx].kind; bus.in_rd = prog[idx].rd; bus.in_rs1 = prog[idx].rs1;
        bus.in_rs2 = prog[idx].rs2; bus.in_funct3 = prog[idx].f3; bus.in_imm = prog[idx].imm;
      end
      #1;
      rdy = bus.in_ready;
      if (done) seen_done = 1'b1;
      if (exp_valid_next) begin
        n_tests++;
        if (!ov) begin n_fail++; $display("FAIL latency: out_valid=%b required 1 (cycle %0d)", ov, cyc); end
      end
      if (prev_stall) begin
        n_tests++;
        if (!ov || bus.out_instr !== prev_i || bus.out_addr !== prev_a) begin
          n_fail++;
          $display("FAIL hold: valid=%b instr=%h addr=%h required 1 %h %h", ov, bus.out_instr, bus.out_addr, prev_i, prev_a);
        end
      end
      exp_rdy  = (idx < n) && (!ov || bus.out_ready) && !seen_done;
      exp_busy = !seen_done;
      n_tests++;
      if (rdy !== exp_rdy) begin n_fail++; $display("FAIL in_ready: got %b required %b (cycle %0d)", rdy, exp_rdy, cyc); end
      n_tests++;
      if (busy !== exp_busy) begin n_fail++; $display("FAIL busy: got %b required %b (cycle %0d)", busy, exp_busy, cyc); end
      if (ov && bus.out_ready) begin
        n_tests++;
        if (exp_i.size() == 0) begin
          n_fail++; $display("FAIL spurious_out: instr=%h addr=%h required none", bus.out_instr, bus.out_addr);
        end else begin
          if (bus.out_instr !== exp_i[0] || bus.out_addr !== exp_a[0]) begin
            n_fail++;
            $display("FAIL out_word: instr=%h addr=%h required %h %h", bus.out_instr, bus.out_addr, exp_i[0], exp_a[0]);
          end
          void'(exp_i.pop_front()); void'(exp_a.pop_front());
        end
        obs_instr.push_back(bus.out_instr); obs_addr.push_back(bus.out_addr);
      end
      exp_valid_next = 1'b0;
      if (bus.in_valid && rdy) begin
        if (model_reject(prog[idx])) rejects++;
        else begin
          exp_i.push_back(model_enc(prog[idx])); exp_a.push_back(addr);
          addr = addr + 32'd4; exp_valid_next = 1'b1;
        end
        idx++;
      end
      prev_stall = ov && !bus.out_ready;
      prev_i = bus.out_instr; prev_a = bus.out_addr;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    done_cycle = cyc; model_rejects = rejects;
    n_tests++;
    if (!seen_done) begin
      n_fail++; $display("FAIL timeout: no done within %0d cycles, required done", budget);
    end else begin
      n_tests++;
      if (exp_i.size() != 0 || idx != n) begin
        n_fail++; $display("FAIL lost: %0d words pending, %0d of %0d consumed, required 0 and all", exp_i.size(), idx, n);
      end
      n_tests++;
      if (err_cnt !== LEN_W'(rejects)) begin
        n_fail++; $display("FAIL err_cnt: got %0d required %0d", err_cnt, rejects);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL done_pulse: done=%b busy=%b required 0 0", done, busy);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if (bus.out_valid !== 0 || bus.in_ready !== 0 || done !== 0 || busy !== 0 ||
        err_cnt !== 0 || bus.out_instr !== 0 || bus.out_addr !== 0) begin
      n_fail++;
      $display("FAIL reset: ov=%b ir=%b done=%b busy=%b err=%0d instr=%h addr=%h required all 0",
               bus.out_valid, bus.in_ready, done, busy, err_cnt, bus.out_instr, bus.out_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    prog.delete();
    prog.push_back(mk(0, 1, 0, 0, 0, 5));
    run_prog(32'h100, 0, 20);
    n_tests++;
    if (obs_instr.size() != 1 || obs_instr[0] !== 32'h00500093 || obs_addr[0] !== 32'h100) begin
      n_fail++; $display("FAIL basic: %0d words first=%h required 1 word 00500093 @100",
                         obs_instr.size(), (obs_instr.size() > 0) ? obs_instr[0] : 32'h0);
    end
  endtask

  task automatic test_store_branch();
    prog.delete();
    prog.push_back(mk(2, 31, 1, 2, 2, 8));
    prog.push_back(mk(3, 7, 1, 2, 0, -4));
    run_prog(32'h2000, 0, 20);
    n_tests++;
    if (obs_instr.size() != 2 || obs_instr[0] !== 32'h0020A423 || obs_instr[1] !== 32'hFE208EE3) begin
      n_fail++; $display("FAIL store_branch: %0d words required 0020a423 fe208ee3", obs_instr.size());
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    prog.delete();
    for (int i = 0; i < 4; i++) prog.push_back(mk(0, i + 1, 2, 0, 0, i * 3));
    run_prog(32'h400, 2, 40);
    ok = (obs_addr.size() == 4);
    for (int i = 0; i < 4 && ok; i++) if (obs_addr[i] !== 32'h400 + 32'(4 * i)) ok = 0;
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL backpressure: %0d words required 4 at 400,404,408,40c", obs_addr.size()); end
  endtask

  task automatic test_range();
    int exp_n, exp_err;
    prog.delete();
    prog.push_back(mk(0, 1, 1, 0, 0, 2048));
    prog.push_back(mk(0, 2, 1, 0, 0, 1));
    prog.push_back(mk(3, 0, 1, 2, 0, 3));
`ifdef INSTR_PACKER_RANGE_CHECK_EN
    exp_n = 1; exp_err = 2;
`else
    exp_n = 3; exp_err = 0;
`endif
    run_prog(32'h800, 0, 20);
    n_tests++;
    if (obs_addr.size() != exp_n || int'(err_cnt) != exp_err || obs_addr[0] !== 32'h800) begin
      n_fail++; $display("FAIL range: %0d words err=%0d required %0d words err=%0d first @800",
                         obs_addr.size(), err_cnt, exp_n, exp_err);
    end
  endtask

  task automatic test_reset_midrun();
    int   waited;
    logic saw_done;
    @(negedge clk);
    start = 1'b1; base_addr = 32'h3000; prog_len = LEN_W'(4);
    bus.in_kind = 2'd0; bus.in_rd = 5'd3; bus.in_rs1 = 5'd4; bus.in_rs2 = 5'd0;
    bus.in_funct3 = 3'd0; bus.in_imm = 32'd9; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!bus.out_valid && waited < 10) begin @(negedge clk); waited++; end
    n_tests++;
    if (!bus.out_valid) begin n_fail++; $display("FAIL midrun_setup: out_valid=0 required 1"); end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.out_valid !== 0 || bus.in_ready !== 0 || busy !== 0 || done !== 0 ||
        bus.out_instr !== 0 || bus.out_addr !== 0 || err_cnt !== 0) begin
      n_fail++; $display("FAIL midrun_reset: ov=%b ir=%b busy=%b done=%b required all 0",
                         bus.out_valid, bus.in_ready, busy, done);
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    saw_done = 0;
    repeat (6) begin @(negedge clk); if (done || busy) saw_done = 1; end
    n_tests++;
    if (saw_done) begin n_fail++; $display("FAIL midrun_done: done/busy seen after reset, required none"); end
    prog.delete();
    prog.push_back(mk(1, 5, 6, 0, 2, -12));
    prog.push_back(mk(2, 0, 6, 7, 2, 20));
    run_prog(32'h3000, 0, 20);
  endtask

  task automatic test_zero_len();
    prog.delete();
    run_prog(32'h500, 0, 20);
    n_tests++;
    if (done_cycle != 3 || obs_instr.size() != 0) begin
      n_fail++; $display("FAIL zero_len: done after %0d cycles with %0d words, required 3 and 0", done_cycle, obs_instr.size());
    end
  endtask

  task automatic test_random();
    logic [31:0] base;
    for (int r = 0; r < 24; r++) begin
      prog.delete();
      for (int i = 0; i < int'($urandom_range(0, 12)); i++)
        prog.push_back(mk($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
                          $urandom_range(0, 31), $urandom_range(0, 7), 0));
      foreach (prog[i]) prog[i].imm = rand_imm();
      base = (r % 4 == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      run_prog(base, (r % 3 == 0) ? 0 : 1, 200);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_kind = '0; bus.in_rd = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_funct3 = '0; bus.in_imm = '0; bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_store_branch();
    test_backpressure();
    test_range();
    test_reset_midrun();
    test_zero_len();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
